arduino_move_tx: RTL and testbench

//  UART 8N1 transmitter: the FPGA-to-Arduino direction of the game link.

---
 rtl/arduino_move_tx_if.sv | 22 ++
 rtl/arduino_move_tx.sv | 169 ++++++++++++++++
 tb/tb_arduino_move_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/arduino_move_tx_if.sv
// Request/status bundle between the game logic and the Arduino UART transmitter.
// The master side issues move/end requests; the slave side drives the line and status.
interface arduino_move_tx_if;
  logic       move_req;
  logic [2:0] move_col;
  logic       end_req;
  logic [1:0] end_result;
  logic       tx;
  logic       busy;
  logic       done;
  logic       dropped;

  modport master (
    output move_req, move_col, end_req, end_result,
    input  tx, busy, done, dropped
  );

  modport slave (
    input  move_req, move_col, end_req, end_result,
    output tx, busy, done, dropped
  );
endinterface

// File: rtl/arduino_move_tx.sv
// UART 8N1 transmitter for the FPGA-to-Arduino game link.
// Each request becomes a 3-byte packet: SYNC (0x55), PAYLOAD, SYNC^PAYLOAD.
// An end-of-game report arriving while busy is held one deep and sent right after.
module arduino_move_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic              clk,
  input  logic              rst,
  arduino_move_tx_if.slave  link
);

  localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int              CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      SYNC         = 8'h55;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic [1:0]       byte_idx, byte_n;
  logic [7:0]       payload, payload_n;
  logic             end_pending, pending_n;
  logic [1:0]       pend_result, pend_res_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             dropped_q, dropped_n;

  logic             move_ok, end_ok, bad_req;
  logic             start_pkt;
  logic [7:0]       start_payload;
  logic [7:0]       next_byte;

  // Register all FSM state and the line/status outputs so tx never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      payload     <= '0;
      end_pending <= 1'b0;
      pend_result <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_idx     <= bit_n;
      byte_idx    <= byte_n;
      payload     <= payload_n;
      end_pending <= pending_n;
      pend_result <= pend_res_n;
      tx_q        <= tx_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      dropped_q   <= dropped_n;
    end
  end

  // Request acceptance, bit/byte sequencing and the next line level.
  always_comb begin
    state_n       = state;
    baud_n        = baud_cnt;
    bit_n         = bit_idx;
    byte_n        = byte_idx;
    payload_n     = payload;
    pending_n     = end_pending;
    pend_res_n    = pend_result;
    busy_n        = busy_q;
    done_n        = 1'b0;
    dropped_n     = 1'b0;
    start_pkt     = 1'b0;
    start_payload = payload;
    next_byte     = SYNC;
    tx_n          = 1'b1;

    move_ok = link.move_req && (link.move_col != 3'd7);
    end_ok  = link.end_req && (link.end_result != 2'b00);
    bad_req = (link.move_req && !move_ok) || (link.end_req && !end_ok);

    if (state == IDLE) begin
      baud_n    = '0;
      dropped_n = bad_req;
      if (move_ok) begin
        start_pkt     = 1'b1;
        start_payload = {2'b01, 3'b000, link.move_col};
        if (end_ok) begin
          pending_n  = 1'b1;
          pend_res_n = link.end_result;
        end
      end else if (end_ok) begin
        start_pkt     = 1'b1;
        start_payload = {2'b10, 4'b0000, link.end_result};
      end
    end else begin
      dropped_n = link.move_req || (link.end_req && !end_ok);
      if (end_ok) begin
        pending_n  = 1'b1;
        pend_res_n = link.end_result;
      end
      if (baud_cnt == LAST_CNT) begin
        baud_n = '0;
        case (state)
          START: begin
            state_n = DATA;
            bit_n   = 3'd0;
          end
          DATA: begin
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_n   = bit_idx + 3'd1;
          end
          STOP: begin
            if (byte_idx != 2'd2) begin
              state_n = START;
              byte_n  = byte_idx + 2'd1;
            end else begin
              done_n = 1'b1;
              if (pending_n) begin
                start_pkt     = 1'b1;
                start_payload = {2'b10, 4'b0000, pend_res_n};
                pending_n     = 1'b0;
              end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end else begin
        baud_n = baud_cnt + 1'b1;
      end
    end

    if (start_pkt) begin
      state_n   = START;
      baud_n    = '0;
      bit_n     = 3'd0;
      byte_n    = 2'd0;
      payload_n = start_payload;
      busy_n    = 1'b1;
    end

    case (byte_n)
      2'd0:    next_byte = SYNC;
      2'd1:    next_byte = payload_n;
      default: next_byte = SYNC ^ payload_n;
    endcase

    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = next_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  assign link.tx      = tx_q;
  assign link.busy    = busy_q;
  assign link.done    = done_q;
  assign link.dropped = dropped_q;

endmodule

// File: tb/tb_arduino_move_tx.sv
// Self-checking bench for arduino_move_tx at 10 clocks per bit (300 clocks per packet).
// Stimulus pushes the hand-computed packet bytes; a UART decoder pops and compares them.
module tb_arduino_move_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         vec_count   = 0;
  int         miss_count  = 0;
  int         cyc         = 0;
  int         done_cnt    = 0;
  int         dropped_cnt = 0;
  logic [7:0] exp_q[$];

  arduino_move_tx_if bus();

  arduino_move_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Tally done and dropped pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.done === 1'b1)    done_cnt    <= done_cnt + 1;
    if (bus.dropped === 1'b1) dropped_cnt <= dropped_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    vec_count++;
    miss_count++;
    $display("[TB] FAIL %s: got timeout/extra event, expected none (cycle %0d)", name, cyc);
  endtask

  // One-cycle request; returns 1 time unit after the edge that sampled it.
  task automatic applyStimulus(input logic mv, input logic [2:0] col, input logic en, input logic [1:0] res);
    @(posedge clk);
    #1;
    bus.move_req   = mv;
    bus.move_col   = col;
    bus.end_req    = en;
    bus.end_result = res;
    @(posedge clk);
    #1;
    bus.move_req = 1'b0;
    bus.end_req  = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) failNow("done_timeout");
  endtask

  task automatic countBusy(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) seen++;
    end
  endtask

  // UART decoder: mid-bit sampling, abandons a byte cut short by reset.
  initial begin : uart_monitor
    logic [7:0] rx;
    logic [7:0] exp_byte;
    logic       aborted;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx === 1'b0) begin
        aborted = 1'b0;
        rx      = '0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          rx[b] = bus.tx;
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        stop_bit = bus.tx;
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_byte");
          end else begin
            exp_byte = exp_q.pop_front();
            checkOutput("rx_byte", {24'd0, rx}, {24'd0, exp_byte});
            checkOutput("stop_bit", {31'd0, stop_bit}, 32'd1);
          end
        end
      end
    end
  end

  // Hard stop if something never finishes.
  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin : stimulus
    int bad, t0, at, seen, got, low, d;
    bus.move_req   = 1'b0;
    bus.move_col   = 3'd0;
    bus.end_req    = 1'b0;
    bus.end_result = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] scenario 1: idle after reset");
    checkOutput("reset_tx", {31'd0, bus.tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dropped !== 1'b0) bad++;
    end
    checkOutput("idle_quiet_cycles", bad, 0);

    $display("[TB] scenario 2: move col 5");
    exp_q.push_back(8'h55); exp_q.push_back(8'h45); exp_q.push_back(8'h10);
    applyStimulus(1'b1, 3'd5, 1'b0, 2'b00);
    t0 = cyc;
    checkOutput("start_tx_low", {31'd0, bus.tx}, 32'd0);
    checkOutput("start_busy", {31'd0, bus.busy}, 32'd1);
    waitDone(400, at);
    checkOutput("done_latency", at - t0, 300);
    checkOutput("busy_after_done", {31'd0, bus.busy}, 32'd0);
    repeat (20) @(negedge clk);

    $display("[TB] scenario 3: end result P2");
    exp_q.push_back(8'h55); exp_q.push_back(8'h82); exp_q.push_back(8'hD7);
    applyStimulus(1'b0, 3'd0, 1'b1, 2'b10);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) seen++;
      else break;
    end
    checkOutput("busy_width", seen, 300);
    repeat (20) @(negedge clk);

    $display("[TB] scenario 4: move col 3 with simultaneous draw");
    exp_q.push_back(8'h55); exp_q.push_back(8'h43); exp_q.push_back(8'h16);
    exp_q.push_back(8'h55); exp_q.push_back(8'h83); exp_q.push_back(8'hD6);
    applyStimulus(1'b1, 3'd3, 1'b1, 2'b11);
    t0 = cyc;
    got = 0;
    low = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got++;
      if (got == 2) break;
      if (bus.busy !== 1'b1) low++;
    end
    checkOutput("chain_done_pulses", got, 2);
    checkOutput("chain_busy_gap", low, 0);
    checkOutput("chain_length", cyc - t0, 600);
    repeat (20) @(negedge clk);

    $display("[TB] scenario 5: rejected requests");
    d = dropped_cnt;
    exp_q.push_back(8'h55); exp_q.push_back(8'h41); exp_q.push_back(8'h14);
    applyStimulus(1'b1, 3'd1, 1'b0, 2'b00);
    t0 = cyc;
    repeat (48) @(posedge clk);
    applyStimulus(1'b1, 3'd2, 1'b0, 2'b00);
    checkOutput("drop_busy_pulse", {31'd0, bus.dropped}, 32'd1);
    waitDone(400, at);
    checkOutput("drop_packet_len", at - t0, 300);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 3'd7, 1'b0, 2'b00);
    checkOutput("drop_col7_pulse", {31'd0, bus.dropped}, 32'd1);
    checkOutput("drop_col7_idle", {31'd0, bus.busy}, 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1, 2'b00);
    checkOutput("drop_result00_pulse", {31'd0, bus.dropped}, 32'd1);
    countBusy(350, seen);
    checkOutput("drop_no_send", seen, 0);
    checkOutput("drop_count", dropped_cnt - d, 3);

    $display("[TB] scenario 6: reset mid-packet with end pending");
    d = done_cnt;
    exp_q.push_back(8'h55);
    applyStimulus(1'b1, 3'd6, 1'b0, 2'b00);
    t0 = cyc;
    repeat (18) @(posedge clk);
    applyStimulus(1'b0, 3'd0, 1'b1, 2'b01);
    checkOutput("pend_not_dropped", {31'd0, bus.dropped}, 32'd0);
    repeat (98) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_abort_edge", cyc - t0, 120);
    checkOutput("reset_abort_tx", {31'd0, bus.tx}, 32'd1);
    checkOutput("reset_abort_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    countBusy(700, seen);
    checkOutput("reset_no_restart", seen, 0);
    checkOutput("reset_no_done", done_cnt - d, 0);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
